wb_cmd_initiator: RTL and testbench

Wishbone initiator that drives the AHB-to-FPGA bridge's slave-side bus (`WBs_*`) from inside the fabric, so gateware logic can issue register reads and writes to the FPGA register file and the QL-reserved block without going through the M4. Commands enter through a valid/ready port and are buffered in a small FIFO. Each command becomes exactly one single-beat Wishbone cycle. Every command, read or write, returns exactly one response on a valid/ready port. An optional bus timeout prevents a hang when a slave never acknowledges.

---
 rtl/wb_cmd_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// Fabric-side Wishbone initiator: FIFO-buffered commands, one single-beat bus cycle and one response each.
// Optional bus timeout is enabled by defining WBM_TIMEOUT_EN.
module wb_cmd_initiator #(
  parameter int                   ADDRWIDTH       = 17,
  parameter int                   DATAWIDTH       = 32,
  parameter int                   FIFO_DEPTH_LOG2 = 2,
  parameter int                   TIMEOUT_CYCLES  = 255,
  parameter logic [DATAWIDTH-1:0] ERR_READ_VALUE  = 32'hBADFABAC
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
  input  logic                 WBs_ACK_i,
  output logic                 busy_o
);

  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage is data only; pointers carry an extra wrap bit for full/empty.
  logic                 r_mem_we  [DEPTH];
  logic [ADDRWIDTH-1:0] r_mem_adr [DEPTH];
  logic [3:0]           r_mem_stb [DEPTH];
  logic [DATAWIDTH-1:0] r_mem_dat [DEPTH];
  logic [PW:0]          r_wr_ptr;
  logic [PW:0]          r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ack_done;
  logic w_to_done;
  logic w_rsp_done;

  logic                 r_cyc;
  logic                 r_we;
  logic [ADDRWIDTH-1:0] r_adr;
  logic [3:0]           r_stb;
  logic [DATAWIDTH-1:0] r_wdat;
  logic                 r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_dat;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = cmd_valid_i & ~w_full;

  always_ff @(posedge WB_CLK) begin
    if (w_push) begin
      r_mem_we [r_wr_ptr[PW-1:0]] <= cmd_we_i;
      r_mem_adr[r_wr_ptr[PW-1:0]] <= cmd_adr_i;
      r_mem_stb[r_wr_ptr[PW-1:0]] <= cmd_byte_stb_i;
      r_mem_dat[r_wr_ptr[PW-1:0]] <= cmd_dat_i;
    end
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

`ifdef WBM_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_rsp_err;
  logic       w_to_hit;

  // Counter value seen at the edge where the TIMEOUT_CYCLES-th BUS cycle ends.
  assign w_to_hit = (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_to_cnt <= '0;
    end else if (w_pop) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_BUS && !WBs_ACK_i) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_rsp_err <= 1'b0;
    end else if (w_ack_done) begin
      r_rsp_err <= 1'b0;
    end else if (w_to_done) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err_o = r_rsp_err;
`else
  logic w_to_hit;
  logic w_unused_cfg;

  assign w_to_hit     = 1'b0;
  assign w_unused_cfg = ^{ERR_READ_VALUE, 32'(TIMEOUT_CYCLES)};
  assign rsp_err_o    = 1'b0;
`endif

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ack_done  = 1'b0;
    w_to_done   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK wins over a timeout landing on the same edge.
        if (WBs_ACK_i) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_to_done   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus-side registers: loaded on pop, held through BUS, left as-is after CYC drops.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_stb  <= '0;
      r_wdat <= '0;
    end else if (w_pop) begin
      r_cyc  <= 1'b1;
      r_we   <= r_mem_we [r_rd_ptr[PW-1:0]];
      r_adr  <= r_mem_adr[r_rd_ptr[PW-1:0]];
      r_stb  <= r_mem_stb[r_rd_ptr[PW-1:0]];
      r_wdat <= r_mem_dat[r_rd_ptr[PW-1:0]];
    end else if (w_ack_done || w_to_done) begin
      r_cyc  <= 1'b0;
    end
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
    end else if (w_ack_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_dat   <= r_we ? '0 : WBs_RD_DAT_i;
    end else if (w_to_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_dat   <= ERR_READ_VALUE;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready_o    = ~w_full;
  assign busy_o         = (r_state != ST_IDLE) || !w_empty;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_dat_o      = r_rsp_dat;
  assign WBs_CYC_o      = r_cyc;
  assign WBs_STB_o      = r_cyc;
  assign WBs_WE_o       = r_we;
  assign WBs_RD_o       = r_cyc & ~r_we;
  assign WBs_ADR_o      = r_adr;
  assign WBs_BYTE_STB_o = r_stb;
  assign WBs_WR_DAT_o   = r_wdat;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with a small byte-enabled register slave.
module tb_wb_cmd_initiator;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [3:0]    cmd_bs = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc, wb_stb, wb_we, wb_rd;
  logic [3:0]    wb_bs;
  logic [DW-1:0] wb_wdat;
  logic [DW-1:0] wb_rdat;
  logic          wb_ack;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH_LOG2(2),
    .TIMEOUT_CYCLES(10), .ERR_READ_VALUE(32'hBADFABAC)
  ) dut (
    .WB_CLK(clk), .WB_RST(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_byte_stb_i(cmd_bs), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .WBs_ADR_o(wb_adr), .WBs_CYC_o(wb_cyc), .WBs_STB_o(wb_stb), .WBs_WE_o(wb_we),
    .WBs_RD_o(wb_rd), .WBs_BYTE_STB_o(wb_bs), .WBs_WR_DAT_o(wb_wdat),
    .WBs_RD_DAT_i(wb_rdat), .WBs_ACK_i(wb_ack), .busy_o(busy)
  );

  // Slave: 8 words at adr[4:2], ACK after s_wait BUS cycles when enabled.
  logic [31:0] smem [8];
  logic        s_ack_en = 1'b1;
  logic [7:0]  s_wait = 8'd0;
  logic [7:0]  s_cnt;

  assign wb_ack  = s_ack_en && wb_cyc && wb_stb && (s_cnt >= s_wait);
  assign wb_rdat = smem[wb_adr[4:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) smem[i] <= 32'h1000_0000 + 32'(i);
      s_cnt <= 8'd0;
    end else begin
      if (wb_cyc && !wb_ack) s_cnt <= s_cnt + 8'd1;
      else                   s_cnt <= 8'd0;
      if (wb_ack && wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_bs[b]) smem[wb_adr[4:2]][8*b +: 8] <= wb_wdat[8*b +: 8];
    end
  end

  // Free-running observation counters, sampled on the falling edge.
  int   ncyc = 0, cyc_hi_total = 0, rise_total = 0, rd_w_total = 0, rd_r_total = 0;
  int   rsp_v_total = 0;
  int   rise_t [64];
  logic prev_cyc = 1'b0;

  always @(negedge clk) begin
    ncyc     <= ncyc + 1;
    prev_cyc <= wb_cyc;
    if (wb_cyc) cyc_hi_total <= cyc_hi_total + 1;
    if (wb_cyc && !prev_cyc) begin
      rise_t[rise_total % 64] <= ncyc;
      rise_total <= rise_total + 1;
    end
    if (wb_cyc && wb_we && wb_rd)  rd_w_total <= rd_w_total + 1;
    if (wb_cyc && !wb_we && wb_rd) rd_r_total <= rd_r_total + 1;
    if (rsp_valid) rsp_v_total <= rsp_v_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] adr, input logic [3:0] bs,
                      input logic [31:0] dat);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_bs = bs; cmd_dat = dat;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] dat, output logic err);
    int n;
    n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("rsp_wait", 32'(rsp_valid), 32'd1);
    dat = rsp_dat;
    err = rsp_err;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) chk("idle_wait", 32'(busy), 32'd0);
  endtask

  logic [31:0] d;
  logic        e;
  int          snap_a, snap_b, snap_c;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_rd", 32'(wb_rd), 32'd0);
    chk("rst_adr", 32'(wb_adr), 32'd0);
    chk("rst_bs", 32'(wb_bs), 32'd0);
    chk("rst_wdat", wb_wdat, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back scratch
    snap_a = rd_w_total; snap_b = rd_r_total;
    push(1'b1, 17'h00008, 4'hF, 32'h1234_5678);
    push(1'b0, 17'h00008, 4'hF, 32'h0);
    get_rsp(d, e);
    chk("wr_rsp_dat", d, 32'h0);
    chk("wr_rsp_err", 32'(e), 32'd0);
    get_rsp(d, e);
    chk("rd_rsp_dat", d, 32'h1234_5678);
    chk("rd_rsp_err", 32'(e), 32'd0);
    wait_idle();
    chk("rd_during_write", 32'(rd_w_total - snap_a), 32'd0);
    chk("rd_during_read", 32'(rd_r_total - snap_b), 32'd1);
    chk("hold_adr", 32'(wb_adr), 32'h00008);
    chk("hold_we", 32'(wb_we), 32'd0);

    // Unaligned address passes through; partial byte strobe merges
    push(1'b1, 17'h1000B, 4'h8, 32'hCC00_0000);
    get_rsp(d, e);
    chk("adr_lsb_adr", 32'(wb_adr), 32'h1000B);
    chk("adr_lsb_bs", 32'(wb_bs), 32'h8);
    chk("adr_lsb_wdat", wb_wdat, 32'hCC00_0000);
    chk("adr_lsb_we", 32'(wb_we), 32'd1);
    push(1'b0, 17'h00008, 4'hF, 32'h0);
    get_rsp(d, e);
    chk("byte_merge", d, 32'hCC34_5678);

    // FIFO fill with responses stalled
    for (int i = 0; i < 5; i++) push(1'b0, 17'(12 + 4*i), 4'hF, 32'h0);
    @(negedge clk);
    chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("fill_cyc", 32'(wb_cyc), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, e);
      chk($sformatf("fill_rsp%0d", i), d, 32'h1000_0003 + 32'(i));
    end
    wait_idle();
    chk("fill_ready_back", 32'(cmd_ready), 32'd1);

    // Throughput: zero-wait slave, responses always accepted
    snap_a = rise_total;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 17'h00010, 4'hF, 32'(i));
    wait_idle();
    rsp_ready = 1'b0;
    chk("thr_rises", 32'(rise_total - snap_a), 32'd4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("thr_gap%0d", i),
          32'(rise_t[(snap_a + i + 1) % 64] - rise_t[(snap_a + i) % 64]), 32'd3);

`ifdef WBM_TIMEOUT_EN
    // Timeout on a silent slave
    s_ack_en = 1'b0;
    snap_a = cyc_hi_total;
    push(1'b0, 17'h00004, 4'hF, 32'h0);
    get_rsp(d, e);
    chk("to_cyc_cycles", 32'(cyc_hi_total - snap_a), 32'd10);
    chk("to_err", 32'(e), 32'd1);
    chk("to_dat", d, 32'hBADFABAC);
    s_ack_en = 1'b1;

    // ACK on the timeout cycle wins
    push(1'b1, 17'h00008, 4'hF, 32'hA5A5_A5A5);
    get_rsp(d, e);
    s_wait = 8'd9;
    snap_a = cyc_hi_total;
    push(1'b0, 17'h00008, 4'hF, 32'h0);
    get_rsp(d, e);
    chk("ackto_cyc_cycles", 32'(cyc_hi_total - snap_a), 32'd10);
    chk("ackto_err", 32'(e), 32'd0);
    chk("ackto_dat", d, 32'hA5A5_A5A5);
    s_wait = 8'd0;
`else
    // Without timeout the bus waits for ACK indefinitely
    s_ack_en = 1'b0;
    push(1'b0, 17'h00008, 4'hF, 32'h0);
    repeat (20) @(negedge clk);
    chk("nto_cyc", 32'(wb_cyc), 32'd1);
    chk("nto_rsp_valid", 32'(rsp_valid), 32'd0);
    s_ack_en = 1'b1;
    get_rsp(d, e);
    chk("nto_err", 32'(e), 32'd0);
    chk("nto_dat", d, 32'hCC34_5678);
`endif

    // Reset mid-transaction with two commands queued
    s_ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 17'(4*i), 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_cyc_before", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_cyc", 32'(wb_cyc), 32'd0);
    chk("mid_stb", 32'(wb_stb), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_ack_en = 1'b1;
    snap_b = rise_total; snap_c = rsp_v_total;
    repeat (20) @(negedge clk);
    chk("mid_no_cyc", 32'(rise_total - snap_b), 32'd0);
    chk("mid_no_rsp", 32'(rsp_v_total - snap_c), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
